// File: rtl/dmem_ctrl.sv
// Data memory for the MIPS core: word-organised RAM behind a valid/ready port with byte/half/word access.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_ctrl #(
   parameter int unsigned DEPTH     = 2048,
   parameter logic [31:0] BASE_ADDR = 32'h10010000,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        we_q, sgn_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic        accept, access;

   logic [31:0] offset;
   logic        range_err, align_err, err;
   logic [AW-1:0] idx;
   logic [3:0]  be;
   logic [31:0] wd, rword, ld;
   logic [7:0]  bsel;
   logic [15:0] hsel;

   logic [31:0] mem [DEPTH];

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      access    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         sgn_q     <= 1'b0;
         size_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY);
         end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (access) begin
            rsp_err   <= err;
            rsp_rdata <= (err || we_q) ? '0 : ld;
         end
      end
   end

   // Offset wraps for addresses below BASE_ADDR, so a single unsigned compare covers both ends.
   always_comb begin
      offset    = addr_q - BASE_ADDR;
      range_err = ({1'b0, offset} >= LIMIT);
      idx       = offset[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
      align_err = (size_q == 2'b01 && addr_q[0]) ||
                  (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
      align_err = 1'b0;
`endif
      err = range_err | align_err | (size_q == 2'b11);
   end

   always_comb begin
      be = 4'b1111;
      wd = wdata_q;
      case (size_q)
         2'b00: begin
            be = 4'b0001 << addr_q[1:0];
            wd = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be = addr_q[1] ? 4'b1100 : 4'b0011;
            wd = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      rword = mem[idx];
      case (addr_q[1:0])
         2'b00:   bsel = rword[7:0];
         2'b01:   bsel = rword[15:8];
         2'b10:   bsel = rword[23:16];
         default: bsel = rword[31:24];
      endcase
      hsel = addr_q[1] ? rword[31:16] : rword[15:0];
      case (size_q)
         2'b00:   ld = {{24{sgn_q & bsel[7]}}, bsel};
         2'b01:   ld = {{16{sgn_q & hsel[15]}}, hsel};
         default: ld = rword;
      endcase
   end

   always_ff @(posedge clk) begin
      if (access && we_q && !err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

endmodule
